// File: rtl/timing_pkg.sv
// Shared definitions for the bus timing sequencer: state encoding, default
// tick counts and small elaboration-time helpers.
package timing_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        MSYN    = 3'd2,
        DESKEW  = 3'd3,
        RELEASE = 3'd4,
        HOLD    = 3'd5
    } state_t;

    localparam int DEF_SETUP_TICKS   = 8;
    localparam int DEF_DESKEW_TICKS  = 4;
    localparam int DEF_HOLD_TICKS    = 2;
    localparam int DEF_TIMEOUT_TICKS = 500;
    localparam int CNT_W             = 10;

    // Counter value seen on the edge that completes a wait of 'ticks' cycles.
    function automatic logic [CNT_W-1:0] last_tick(input int ticks);
        return (ticks > 0) ? CNT_W'(ticks - 1) : '0;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/timing_seq_edge.sv
// Start rising-edge detector; edges are ignored for the first two cycles
// after reset release so a start held high across reset cannot fire.
module seq_edge (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic pulse
);

    logic       start_q;
    logic [1:0] init_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q  <= 1'b0;
            init_cnt <= 2'd0;
        end else begin
            start_q <= start;
            if (init_cnt != 2'd2)
                init_cnt <= init_cnt + 2'd1;
        end
    end

    assign pulse = start & ~start_q & (init_cnt == 2'd2);

endmodule

// File: rtl/timing_seq.sv
// Master-side bus cycle sequencer (address setup, msyn/ssyn handshake, deskew,
// hold). Define TIMING_SEQ_TIMEOUT_EN to abort on a missing slave response.
module timing_seq
    import timing_pkg::*;
#(
    parameter int SETUP_TICKS   = DEF_SETUP_TICKS,
    parameter int DESKEW_TICKS  = DEF_DESKEW_TICKS,
    parameter int HOLD_TICKS    = DEF_HOLD_TICKS,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic dati,
    input  logic ssyn,
    output logic ale,
    output logic data_oe,
    output logic msyn,
    output logic latch,
    output logic busy,
    output logic done,
    output logic err
);

    localparam logic [CNT_W-1:0] SETUP_LAST  = last_tick(SETUP_TICKS);
    localparam logic [CNT_W-1:0] DESKEW_LAST = last_tick(DESKEW_TICKS);
    localparam logic [CNT_W-1:0] HOLD_LAST   = last_tick(HOLD_TICKS);
    localparam int CNT_MAX = max_int(max_int(SETUP_TICKS, DESKEW_TICKS),
                                     max_int(HOLD_TICKS, TIMEOUT_TICKS));
    // Counter parks at the longest wait so a long stall never wraps it.
    localparam logic [CNT_W-1:0] CNT_SAT = (CNT_MAX >= (1 << CNT_W)) ?
                                           {CNT_W{1'b1}} : CNT_W'(CNT_MAX);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             ssyn_m, ssyn_s;
    logic             start_edge;
    logic             rd, rd_d;
    logic             ale_d, oe_d, msyn_d, latch_d, busy_d, done_d;

`ifdef TIMING_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = last_tick(TIMEOUT_TICKS);
    logic err_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ssyn_m <= 1'b0;
            ssyn_s <= 1'b0;
        end else begin
            ssyn_m <= ssyn;
            ssyn_s <= ssyn_m;
        end
    end

    seq_edge u_edge (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .pulse (start_edge)
    );

    always_comb begin
        state_d = state;
        rd_d    = rd;
        ale_d   = ale;
        oe_d    = data_oe;
        msyn_d  = msyn;
        busy_d  = busy;
        latch_d = 1'b0;
        done_d  = 1'b0;
`ifdef TIMING_SEQ_TIMEOUT_EN
        err_d   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_d = SETUP;
                    rd_d    = dati;
                    ale_d   = 1'b1;
                    oe_d    = ~dati;
                    busy_d  = 1'b1;
                end
            end
            SETUP: begin
                // A slave still holding ssyn from a previous cycle stalls us here.
                if (cnt >= SETUP_LAST && !ssyn_s) begin
                    state_d = MSYN;
                    msyn_d  = 1'b1;
                end
            end
            MSYN: begin
                if (ssyn_s)
                    state_d = DESKEW;
`ifdef TIMING_SEQ_TIMEOUT_EN
                else if (cnt >= TIMEOUT_LAST) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    ale_d   = 1'b0;
                    oe_d    = 1'b0;
                    msyn_d  = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end
`endif
            end
            DESKEW: begin
                if (cnt >= DESKEW_LAST) begin
                    state_d = RELEASE;
                    msyn_d  = 1'b0;
                    latch_d = rd;
                end
            end
            RELEASE: begin
                if (!ssyn_s)
                    state_d = HOLD;
`ifdef TIMING_SEQ_TIMEOUT_EN
                else if (cnt >= TIMEOUT_LAST) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    ale_d   = 1'b0;
                    oe_d    = 1'b0;
                    msyn_d  = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end
`endif
            end
            HOLD: begin
                if (cnt >= HOLD_LAST) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    ale_d   = 1'b0;
                    oe_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt;
        if (state_d != state)
            cnt_d = '0;
        else if (cnt != CNT_SAT)
            cnt_d = cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rd      <= 1'b0;
            ale     <= 1'b0;
            data_oe <= 1'b0;
            msyn    <= 1'b0;
            latch   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            rd      <= rd_d;
            ale     <= ale_d;
            data_oe <= oe_d;
            msyn    <= msyn_d;
            latch   <= latch_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

`ifdef TIMING_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err <= 1'b0;
        else
            err <= err_d;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_timing_seq.sv
// Directed bench for timing_seq: edge times are recorded by a negedge monitor
// and compared against hand-computed cycle numbers in each scenario task.
module tb_timing_seq;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, dati = 1'b0, ssyn = 1'b0;
    logic ale, data_oe, msyn, latch, busy, done, err;
    int   total = 0, bad = 0, cyc = 0;

    timing_seq dut (
        .clk(clk), .reset(reset), .start(start), .dati(dati), .ssyn(ssyn),
        .ale(ale), .data_oe(data_oe), .msyn(msyn), .latch(latch),
        .busy(busy), .done(done), .err(err)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    // First-occurrence edge times (cycle index of the causing posedge) and counts.
    int t_ale_r, t_ale_f, t_oe_r, t_oe_f, t_busy_r, t_busy_f, t_msyn_r, t_msyn_f;
    int t_latch, t_done, t_done_f, t_err, n_latch, n_done, n_err, n_oe, n_ale_r;
    logic p_ale = 0, p_oe = 0, p_busy = 0, p_msyn = 0, p_latch = 0, p_done = 0, p_err = 0;

    always @(negedge clk) begin
        if (ale && !p_ale && t_ale_r < 0) t_ale_r = cyc;
        if (!ale && p_ale && t_ale_f < 0) t_ale_f = cyc;
        if (data_oe && !p_oe && t_oe_r < 0) t_oe_r = cyc;
        if (!data_oe && p_oe && t_oe_f < 0) t_oe_f = cyc;
        if (busy && !p_busy && t_busy_r < 0) t_busy_r = cyc;
        if (!busy && p_busy && t_busy_f < 0) t_busy_f = cyc;
        if (msyn && !p_msyn && t_msyn_r < 0) t_msyn_r = cyc;
        if (!msyn && p_msyn && t_msyn_f < 0) t_msyn_f = cyc;
        if (latch && !p_latch && t_latch < 0) t_latch = cyc;
        if (done && !p_done && t_done < 0) t_done = cyc;
        if (!done && p_done && t_done_f < 0) t_done_f = cyc;
        if (err && !p_err && t_err < 0) t_err = cyc;
        if (ale && !p_ale) n_ale_r++;
        if (latch) n_latch++;
        if (done) n_done++;
        if (err) n_err++;
        if (data_oe) n_oe++;
        {p_ale, p_oe, p_busy, p_msyn, p_latch, p_done, p_err} =
            {ale, data_oe, busy, msyn, latch, done, err};
    end

    task automatic clr_mon();
        {t_ale_r, t_ale_f, t_oe_r, t_oe_f} = {-32'sd1, -32'sd1, -32'sd1, -32'sd1};
        {t_busy_r, t_busy_f, t_msyn_r, t_msyn_f} = {-32'sd1, -32'sd1, -32'sd1, -32'sd1};
        {t_latch, t_done, t_done_f, t_err} = {-32'sd1, -32'sd1, -32'sd1, -32'sd1};
        {n_latch, n_done, n_err, n_oe, n_ale_r} = '0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic test_reset();
        start = 1'b1;
        step(3);
        total++; if ({ale, data_oe, msyn, latch, busy, done, err} !== 7'b0) begin
            bad++; $display("FAIL rst_outputs got=%b exp=0000000", {ale, data_oe, msyn, latch, busy, done, err}); end
        reset = 1'b0;
        step(6);
        total++; if ({ale, busy} !== 2'b00) begin
            bad++; $display("FAIL rst_init_gate got=%b exp=00", {ale, busy}); end
        start = 1'b0;
        step(2);
    endtask

    task automatic test_write();
        int k0, x, z;
        clr_mon();
        k0 = cyc; dati = 1'b0; start = 1'b1;
        step(2); start = 1'b0;
        x = k0 + 19; goto(x); ssyn = 1'b1;
        z = x + 12; goto(z); ssyn = 1'b0;
        goto(z + 10);
        total++; if (t_ale_r !== k0 + 1) begin bad++; $display("FAIL wr_ale_rise got=%0d exp=%0d", t_ale_r, k0 + 1); end
        total++; if (t_oe_r !== k0 + 1) begin bad++; $display("FAIL wr_oe_rise got=%0d exp=%0d", t_oe_r, k0 + 1); end
        total++; if (t_busy_r !== k0 + 1) begin bad++; $display("FAIL wr_busy_rise got=%0d exp=%0d", t_busy_r, k0 + 1); end
        total++; if (t_msyn_r !== k0 + 9) begin bad++; $display("FAIL wr_msyn_rise got=%0d exp=%0d", t_msyn_r, k0 + 9); end
        total++; if (t_msyn_f !== x + 7) begin bad++; $display("FAIL wr_msyn_fall got=%0d exp=%0d", t_msyn_f, x + 7); end
        total++; if (n_latch !== 0) begin bad++; $display("FAIL wr_latch got=%0d exp=0", n_latch); end
        total++; if (t_done !== z + 5) begin bad++; $display("FAIL wr_done got=%0d exp=%0d", t_done, z + 5); end
        total++; if (t_done_f !== z + 6) begin bad++; $display("FAIL wr_done_width got=%0d exp=%0d", t_done_f, z + 6); end
        total++; if (t_ale_f !== z + 5) begin bad++; $display("FAIL wr_ale_fall got=%0d exp=%0d", t_ale_f, z + 5); end
        total++; if (t_oe_f !== z + 5) begin bad++; $display("FAIL wr_oe_fall got=%0d exp=%0d", t_oe_f, z + 5); end
        total++; if (t_busy_f !== z + 5) begin bad++; $display("FAIL wr_busy_fall got=%0d exp=%0d", t_busy_f, z + 5); end
    endtask

    task automatic test_read();
        int k0, x, z;
        clr_mon();
        k0 = cyc; dati = 1'b1; start = 1'b1;
        step(2); start = 1'b0;
        x = k0 + 19; goto(x); ssyn = 1'b1;
        z = x + 12; goto(z); ssyn = 1'b0;
        goto(z + 10); dati = 1'b0;
        total++; if (t_msyn_f !== x + 7) begin bad++; $display("FAIL rd_msyn_fall got=%0d exp=%0d", t_msyn_f, x + 7); end
        total++; if (t_latch !== x + 7) begin bad++; $display("FAIL rd_latch_time got=%0d exp=%0d", t_latch, x + 7); end
        total++; if (n_latch !== 1) begin bad++; $display("FAIL rd_latch_width got=%0d exp=1", n_latch); end
        total++; if (n_oe !== 0) begin bad++; $display("FAIL rd_data_oe got=%0d exp=0", n_oe); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL rd_done_count got=%0d exp=1", n_done); end
        total++; if (t_done !== z + 5) begin bad++; $display("FAIL rd_done got=%0d exp=%0d", t_done, z + 5); end
    endtask

    task automatic test_deskew_start();
        int k0, x, z;
        clr_mon();
        k0 = cyc; start = 1'b1;
        step(2); start = 1'b0;
        x = k0 + 19; goto(x); ssyn = 1'b1;
        goto(x + 3); start = 1'b1;
        step(2); start = 1'b0;
        z = x + 12; goto(z); ssyn = 1'b0;
        goto(z + 25);
        total++; if (n_ale_r !== 1) begin bad++; $display("FAIL ds_ale_rises got=%0d exp=1", n_ale_r); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL ds_done_count got=%0d exp=1", n_done); end
        total++; if (t_done !== z + 5) begin bad++; $display("FAIL ds_done got=%0d exp=%0d", t_done, z + 5); end
        total++; if ({ale, busy} !== 2'b00) begin bad++; $display("FAIL ds_idle got=%b exp=00", {ale, busy}); end
    endtask

    task automatic test_ssyn_high();
        int k0, d, x, z;
        clr_mon();
        k0 = cyc; ssyn = 1'b1; start = 1'b1;
        step(2); start = 1'b0;
        d = k0 + 21; goto(d);
        total++; if ({msyn, busy} !== 2'b01) begin bad++; $display("FAIL sh_stall got=%b exp=01", {msyn, busy}); end
        total++; if (t_msyn_r !== -1) begin bad++; $display("FAIL sh_no_msyn got=%0d exp=-1", t_msyn_r); end
        ssyn = 1'b0;
        x = d + 13; goto(x);
        total++; if (t_msyn_r !== d + 3) begin bad++; $display("FAIL sh_msyn_rise got=%0d exp=%0d", t_msyn_r, d + 3); end
        ssyn = 1'b1;
        z = x + 12; goto(z); ssyn = 1'b0;
        goto(z + 10);
        total++; if (t_done !== z + 5) begin bad++; $display("FAIL sh_done got=%0d exp=%0d", t_done, z + 5); end
    endtask

    task automatic test_reset_mid();
        int k0, r, x, z;
        clr_mon();
        k0 = cyc; start = 1'b1;
        step(2); start = 1'b0;
        goto(k0 + 12);
        total++; if ({ale, msyn, busy} !== 3'b111) begin bad++; $display("FAIL rm_in_msyn got=%b exp=111", {ale, msyn, busy}); end
        reset = 1'b1; #1;
        total++; if ({ale, data_oe, msyn, latch, busy, done, err} !== 7'b0) begin
            bad++; $display("FAIL rm_async got=%b exp=0000000", {ale, data_oe, msyn, latch, busy, done, err}); end
        step(1); reset = 1'b0; r = cyc;
        clr_mon();
        goto(r + 2); start = 1'b1;
        step(2); start = 1'b0;
        x = r + 21; goto(x); ssyn = 1'b1;
        z = x + 12; goto(z); ssyn = 1'b0;
        goto(z + 10);
        total++; if (t_ale_r !== r + 3) begin bad++; $display("FAIL rm_restart got=%0d exp=%0d", t_ale_r, r + 3); end
        total++; if (t_msyn_r !== r + 11) begin bad++; $display("FAIL rm_msyn_rise got=%0d exp=%0d", t_msyn_r, r + 11); end
        total++; if (t_done !== z + 5) begin bad++; $display("FAIL rm_done got=%0d exp=%0d", t_done, z + 5); end
    endtask

    task automatic test_timeout();
        int k0, m0;
        clr_mon();
        k0 = cyc; ssyn = 1'b0; start = 1'b1;
        step(2); start = 1'b0;
        m0 = k0 + 9;
`ifdef TIMING_SEQ_TIMEOUT_EN
        goto(m0 + 505);
        total++; if (t_err !== m0 + 500) begin bad++; $display("FAIL to_err_time got=%0d exp=%0d", t_err, m0 + 500); end
        total++; if (n_err !== 1) begin bad++; $display("FAIL to_err_width got=%0d exp=1", n_err); end
        total++; if ({ale, data_oe, msyn, busy, err} !== 5'b0) begin
            bad++; $display("FAIL to_outputs got=%b exp=00000", {ale, data_oe, msyn, busy, err}); end
        total++; if (n_done !== 0) begin bad++; $display("FAIL to_no_done got=%0d exp=0", n_done); end
`else
        goto(m0 + 1000);
        total++; if ({msyn, busy} !== 2'b11) begin bad++; $display("FAIL to_wait got=%b exp=11", {msyn, busy}); end
        total++; if (n_err !== 0) begin bad++; $display("FAIL to_err_tied got=%0d exp=0", n_err); end
`endif
        reset = 1'b1; step(1); reset = 1'b0; step(4);
    endtask

    initial begin
        clr_mon();
        test_reset();
        test_write();
        test_read();
        test_deskew_start();
        test_ssyn_high();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
